// File: rtl/fproc_meas_lut_if.sv
// Per-core request/response bundle between the proc cores and the meas/LUT distributor.
// Latency: none (wires only).
// Backpressure: none; each core holds a single outstanding request and waits for its one-cycle ready pulse.
interface fproc_meas_lut_if #(
  parameter int N_CORES = 5,
  parameter int ID_W    = 3,
  parameter int DATA_W  = 32
);
  logic [N_CORES-1:0]        core_enable;
  logic [N_CORES*ID_W-1:0]   core_id;
  logic [N_CORES-1:0]        core_ready;
  logic [N_CORES*DATA_W-1:0] core_data;

  // Core side issues requests and consumes responses
  modport master (output core_enable, output core_id, input core_ready, input core_data);
  // Distributor side accepts requests and returns responses
  modport slave  (input core_enable, input core_id, output core_ready, output core_data);
endinterface

// File: rtl/fproc_meas_lut.sv
// Distributes per-channel measurement outcomes or a masked-address LUT word to N_CORES proc cores.
// Latency: meas strobe -> core_ready 1 cycle; completing strobe -> lut_done 1 cycle -> core_ready 1 more.
// Backpressure: none; requests arriving while a core is busy are ignored. Optional wait timeout: FPROC_LUT_TIMEOUT_EN.
module fproc_meas_lut #(
  parameter int N_CORES        = 5,
  parameter int N_MEAS         = 5,
  parameter int DATA_W         = 32,
  parameter int ID_W           = $clog2(N_MEAS + 1),
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CFG_W         = (N_CORES > N_MEAS) ? N_CORES : N_MEAS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_MEAS-1:0] meas,
  input  logic [N_MEAS-1:0] meas_valid,
  fproc_meas_lut_if.slave   core_if,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [N_MEAS-1:0] cfg_addr,
  input  logic [CFG_W-1:0]  cfg_wdata
);

  localparam int LUT_D = 2 ** N_MEAS;

  // Reject configurations the response format cannot represent
  if (DATA_W < 2) begin : g_bad_data_w
    $error("DATA_W must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {C_IDLE, C_WAIT_MEAS, C_WAIT_LUT} core_state_e;
  typedef enum logic {L_ACCUM, L_DONE} lut_state_e;

  // LUT side state
  lut_state_e          lut_state_q, lut_state_d;
  logic [N_MEAS-1:0]   acc_valid_q, acc_valid_d;
  logic [N_MEAS-1:0]   acc_addr_q, acc_addr_d;
  logic [N_MEAS-1:0]   mask_q, mask_d;
  logic [N_CORES-1:0]  lut_word_q, lut_word_d;
  logic [N_CORES-1:0]  mem_q [LUT_D];
  logic [N_CORES-1:0]  mem_d [LUT_D];
  logic [N_MEAS-1:0]   new_valid, new_addr;
  logic                mask_wr, lut_complete, lut_done;

  // Per-core state
  core_state_e         cst_q [N_CORES];
  core_state_e         cst_d [N_CORES];
  logic [ID_W-1:0]     ch_q  [N_CORES];
  logic [ID_W-1:0]     ch_d  [N_CORES];
  logic [ID_W-1:0]     req_id [N_CORES];
  logic [N_CORES-1:0]  rdy_q, rdy_d, res_q, res_d, tof_q, tof_d;
  logic [N_CORES-1:0]  ev, ev_bit, err, tmo;
  logic [N_CORES*DATA_W-1:0] data_flat;

`ifdef FPROC_LUT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q [N_CORES];
  logic [CNT_W-1:0] cnt_d [N_CORES];
`endif

  // All state registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      lut_state_q <= L_ACCUM;
      acc_valid_q <= '0;
      acc_addr_q  <= '0;
      mask_q      <= '0;
      lut_word_q  <= '0;
      for (int a = 0; a < LUT_D; a++) mem_q[a] <= '0;
      for (int i = 0; i < N_CORES; i++) begin
        cst_q[i] <= C_IDLE;
        ch_q[i]  <= '0;
`ifdef FPROC_LUT_TIMEOUT_EN
        cnt_q[i] <= '0;
`endif
      end
      rdy_q <= '0;
      res_q <= '0;
      tof_q <= '0;
    end else begin
      lut_state_q <= lut_state_d;
      acc_valid_q <= acc_valid_d;
      acc_addr_q  <= acc_addr_d;
      mask_q      <= mask_d;
      lut_word_q  <= lut_word_d;
      for (int a = 0; a < LUT_D; a++) mem_q[a] <= mem_d[a];
      for (int i = 0; i < N_CORES; i++) begin
        cst_q[i] <= cst_d[i];
        ch_q[i]  <= ch_d[i];
`ifdef FPROC_LUT_TIMEOUT_EN
        cnt_q[i] <= cnt_d[i];
`endif
      end
      rdy_q <= rdy_d;
      res_q <= res_d;
      tof_q <= tof_d;
    end
  end

  // Merge this cycle's masked strobes into the accumulator; DONE restarts from empty so new strobes seed it
  always_comb begin
    mask_wr      = cfg_we & cfg_sel;
    new_valid    = ((lut_state_q == L_DONE) ? '0 : acc_valid_q) | (meas_valid & mask_q);
    new_addr     = ((lut_state_q == L_DONE) ? '0 : acc_addr_q) | (meas_valid & mask_q & meas);
    lut_complete = (lut_state_q == L_ACCUM) && (mask_q != '0) && (new_valid == mask_q);
  end

  // LUT FSM next state; a mask write always wins and restarts accumulation
  always_comb begin
    lut_state_d = lut_state_q;
    if (mask_wr)           lut_state_d = L_ACCUM;
    else if (lut_complete) lut_state_d = L_DONE;
    else if (lut_state_q == L_DONE) lut_state_d = L_ACCUM;
  end

  // LUT datapath: accumulator, lookup (reads pre-write memory), config writes
  always_comb begin
    acc_valid_d = new_valid;
    acc_addr_d  = new_addr;
    mask_d      = mask_q;
    lut_word_d  = lut_word_q;
    for (int a = 0; a < LUT_D; a++) mem_d[a] = mem_q[a];
    if (mask_wr) begin
      mask_d      = cfg_wdata[N_MEAS-1:0];
      acc_valid_d = '0;
      acc_addr_d  = '0;
    end else if (lut_complete) begin
      lut_word_d  = mem_q[new_addr];
      acc_valid_d = '0;
      acc_addr_d  = '0;
    end
    if (cfg_we && !cfg_sel) mem_d[cfg_addr] = cfg_wdata[N_CORES-1:0];
  end

  // LUT FSM output: one-cycle completion strobe to the cores
  assign lut_done = (lut_state_q == L_DONE);

  // Per-core event detection: same-cycle events count for a request made in IDLE
  always_comb begin
    for (int i = 0; i < N_CORES; i++) begin
      req_id[i] = core_if.core_id[i*ID_W +: ID_W];
      ev[i]     = 1'b0;
      ev_bit[i] = 1'b0;
      err[i]    = 1'b0;
      tmo[i]    = 1'b0;
      unique case (cst_q[i])
        C_IDLE: begin
          if (core_if.core_enable[i]) begin
            if (req_id[i] == '0) begin
              ev[i]     = lut_done;
              ev_bit[i] = lut_word_q[i];
            end else if (req_id[i] <= ID_W'(N_MEAS)) begin
              ev[i]     = meas_valid[req_id[i] - ID_W'(1)];
              ev_bit[i] = meas[req_id[i] - ID_W'(1)];
            end else begin
              err[i] = 1'b1;
            end
          end
        end
        C_WAIT_MEAS: begin
          ev[i]     = meas_valid[ch_q[i]];
          ev_bit[i] = meas[ch_q[i]];
        end
        C_WAIT_LUT: begin
          ev[i]     = lut_done;
          ev_bit[i] = lut_word_q[i];
        end
        default: ;
      endcase
`ifdef FPROC_LUT_TIMEOUT_EN
      tmo[i] = (cst_q[i] != C_IDLE) && !ev[i] && (cnt_q[i] == CNT_W'(TIMEOUT_CYCLES - 1));
`endif
    end
  end

  // Per-core FSM next state; the wait counter restarts whenever the core is idle
  always_comb begin
    for (int i = 0; i < N_CORES; i++) begin
      cst_d[i] = cst_q[i];
      ch_d[i]  = ch_q[i];
      if (cst_q[i] == C_IDLE) begin
        if (core_if.core_enable[i] && !ev[i] && !err[i]) begin
          if (req_id[i] == '0) begin
            cst_d[i] = C_WAIT_LUT;
          end else begin
            cst_d[i] = C_WAIT_MEAS;
            ch_d[i]  = req_id[i] - ID_W'(1);
          end
        end
      end else if (ev[i] || tmo[i]) begin
        cst_d[i] = C_IDLE;
      end
`ifdef FPROC_LUT_TIMEOUT_EN
      cnt_d[i] = (cst_q[i] == C_IDLE) ? '0 : cnt_q[i] + CNT_W'(1);
`endif
    end
  end

  // Per-core response: pulse ready, update result/flag, otherwise hold the last response
  always_comb begin
    for (int i = 0; i < N_CORES; i++) begin
      rdy_d[i] = ev[i] | err[i] | tmo[i];
      res_d[i] = res_q[i];
      tof_d[i] = tof_q[i];
      if (ev[i]) begin
        res_d[i] = ev_bit[i];
        tof_d[i] = 1'b0;
      end else if (err[i] || tmo[i]) begin
        res_d[i] = 1'b0;
        tof_d[i] = 1'b1;
      end
    end
  end

  // Expand the registered result/flag bits into the per-core data words
  always_comb begin
    data_flat = '0;
    for (int i = 0; i < N_CORES; i++) begin
      data_flat[i*DATA_W]              = res_q[i];
      data_flat[i*DATA_W + DATA_W - 1] = tof_q[i];
    end
  end

  assign core_if.core_ready = rdy_q;
  assign core_if.core_data  = data_flat;

endmodule

// File: tb/tb_fproc_meas_lut.sv
// Directed bench for fproc_meas_lut with a response scoreboard.
// Expected responses are queued with their due cycle when stimulus is driven.
// Build with +define+FPROC_LUT_TIMEOUT_EN to exercise the wait timeout.
module tb_fproc_meas_lut;
  localparam int N_CORES = 5;
  localparam int N_MEAS  = 5;
  localparam int DATA_W  = 32;
  localparam int ID_W    = $clog2(N_MEAS + 1);
  localparam int TMO     = 16;

  typedef struct {
    int                core;
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  logic              clk;
  logic              reset;
  logic [N_MEAS-1:0] meas;
  logic [N_MEAS-1:0] meas_valid;
  logic              cfg_we;
  logic              cfg_sel;
  logic [N_MEAS-1:0] cfg_addr;
  logic [N_MEAS-1:0] cfg_wdata;

  exp_t sbq[$];
  int   cyc;
  int   checks;
  int   failures;

  fproc_meas_lut_if #(.N_CORES(N_CORES), .ID_W(ID_W), .DATA_W(DATA_W)) dut_if ();

  fproc_meas_lut #(
    .N_CORES(N_CORES), .N_MEAS(N_MEAS), .DATA_W(DATA_W), .ID_W(ID_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .meas(meas), .meas_valid(meas_valid), .core_if(dut_if),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_rsp(input int c, input logic d0, input logic flag, input int lat);
    logic [DATA_W-1:0] d;
    d = '0;
    d[0] = d0;
    d[DATA_W-1] = flag;
    sbq.push_back('{core: c, data: d, due: cyc + lat});
  endtask

  // Advance one clock, then score every ready pulse and any overdue expectation
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < N_CORES; c++) begin
      if (dut_if.core_ready[c]) begin
        int idx;
        idx = -1;
        foreach (sbq[k]) if (idx < 0 && sbq[k].core == c) idx = k;
        if (idx < 0) begin
          chk($sformatf("unexpected_ready_core%0d", c), 64'(dut_if.core_ready[c]), 64'd0);
        end else begin
          chk($sformatf("ready_cycle_core%0d", c), 64'(cyc), 64'(sbq[idx].due));
          chk($sformatf("ready_data_core%0d", c), 64'(dut_if.core_data[c*DATA_W +: DATA_W]),
              64'(sbq[idx].data));
          sbq.delete(idx);
        end
      end
    end
    for (int k = sbq.size() - 1; k >= 0; k--) begin
      if (sbq[k].due < cyc) begin
        chk($sformatf("missed_ready_core%0d", sbq[k].core), 64'(dut_if.core_ready[sbq[k].core]), 64'd1);
        sbq.delete(k);
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic clr();
    meas = '0;
    meas_valid = '0;
    cfg_we = 1'b0;
    cfg_sel = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    dut_if.core_enable = '0;
    dut_if.core_id = '0;
  endtask

  task automatic req(input int c, input int id);
    dut_if.core_enable[c] = 1'b1;
    dut_if.core_id[c*ID_W +: ID_W] = ID_W'(id);
  endtask

  task automatic strobe(input int ch, input logic v);
    meas_valid[ch] = 1'b1;
    meas[ch] = v;
  endtask

  task automatic cfg(input logic sel, input int addr, input logic [N_MEAS-1:0] wd);
    cfg_we = 1'b1;
    cfg_sel = sel;
    cfg_addr = N_MEAS'(addr);
    cfg_wdata = wd;
  endtask

  initial begin
    cyc = 0;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    clr();
    ticks(3);
    reset = 1'b0;
    tick();
    chk("reset_ready", 64'(dut_if.core_ready), 64'd0);
    chk("reset_data", 64'(dut_if.core_data), 64'd0);

    // Core 2 waits on channel 2; an unrelated channel strobe must not answer it
    req(2, 3);
    tick(); clr();
    ticks(2);
    strobe(0, 1'b1);
    tick(); clr();
    tick();
    strobe(2, 1'b1);
    expect_rsp(2, 1'b1, 1'b0, 1);
    tick(); clr();
    ticks(3);
    chk("hold_core2", 64'(dut_if.core_data[2*DATA_W +: DATA_W]), 64'd1);

    // LUT lookup on channels 0/1; unmasked channel 3 must not disturb the address
    cfg(1'b1, 0, 5'b00011);
    tick(); clr();
    cfg(1'b0, 2, 5'b10000);
    tick(); clr();
    req(0, 0);
    req(4, 0);
    tick(); clr();
    ticks(2);
    strobe(1, 1'b1);
    strobe(3, 1'b1);
    tick(); clr();
    tick();
    strobe(0, 1'b0);
    expect_rsp(4, 1'b1, 1'b0, 2);
    expect_rsp(0, 1'b0, 1'b0, 2);
    tick(); clr();
    ticks(3);

    // Request and matching strobe in the same cycle; leaves channel 0 in the accumulator
    req(1, 1);
    req(3, 5);
    strobe(0, 1'b1);
    strobe(4, 1'b0);
    expect_rsp(1, 1'b1, 1'b0, 1);
    expect_rsp(3, 1'b0, 1'b0, 1);
    tick(); clr();
    ticks(2);

    // Mask rewrite discards the held channel 0; a lone channel 1 strobe must not complete
    cfg(1'b1, 0, 5'b00011);
    tick(); clr();
    cfg(1'b0, 2, 5'b00010);
    tick(); clr();
    req(1, 0);
    tick(); clr();
    strobe(1, 1'b1);
    tick(); clr();
    ticks(4);
    // Completing lookup coincides with a write to the same word: old word is returned
    strobe(0, 1'b0);
    cfg(1'b0, 2, 5'b00000);
    expect_rsp(1, 1'b1, 1'b0, 2);
    tick(); clr();
    ticks(3);

    // Out-of-range ids answer immediately with the timeout flag
    req(0, 7);
    req(4, 6);
    expect_rsp(0, 1'b0, 1'b1, 1);
    expect_rsp(4, 1'b0, 1'b1, 1);
    tick(); clr();
    ticks(2);

    // Mask of zero: the LUT never completes
    cfg(1'b1, 0, 5'b00000);
    tick(); clr();
    req(2, 0);
`ifdef FPROC_LUT_TIMEOUT_EN
    expect_rsp(2, 1'b0, 1'b1, TMO + 1);
    tick(); clr();
    strobe(0, 1'b1);
    strobe(1, 1'b1);
    tick(); clr();
    ticks(TMO + 3);
    chk("timeout_data_core2", 64'(dut_if.core_data[2*DATA_W +: DATA_W]), 64'h8000_0000);
`else
    tick(); clr();
    strobe(0, 1'b1);
    strobe(1, 1'b1);
    tick(); clr();
    ticks(30);
    chk("mask0_no_ready", 64'(dut_if.core_ready), 64'd0);
    chk("mask0_hold_core2", 64'(dut_if.core_data[2*DATA_W +: DATA_W]), 64'd1);
`endif

    // Reset while core 3 waits on channel 4: the later strobe must be dropped
    req(3, 5);
    tick(); clr();
    ticks(2);
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    tick();
    strobe(4, 1'b1);
    tick(); clr();
    ticks(3);
    chk("post_reset_ready", 64'(dut_if.core_ready), 64'd0);
    chk("post_reset_data", 64'(dut_if.core_data), 64'd0);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
